// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding from Memory/Writeback into Execute for
// NUM_SRC source operands, plus a load-use stall controller that holds
// Fetch/Decode and bubbles Execute for 1+LOAD_LAT cycles per hazard.
// Optional build macro FWD_STATS_EN adds 32-bit forwarding/stall statistics
// counters (fwd_count_m, fwd_count_w, stall_count); when it is undefined the
// counter ports and logic are absent.
module fwd_hazard_unit #(
  parameter int WIDTH      = 32,
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_d,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_e,
  input  logic [NUM_SRC*WIDTH-1:0]      rd_data_e,
  input  logic [REG_ADDR_W-1:0]         rd_e,
  input  logic [REG_ADDR_W-1:0]         rd_m,
  input  logic [REG_ADDR_W-1:0]         rd_w,
  input  logic                          reg_write_e,
  input  logic                          reg_write_m,
  input  logic                          reg_write_w,
  input  logic                          load_e,
  input  logic                          flush_req,
  input  logic [WIDTH-1:0]              alu_result_m,
  input  logic [WIDTH-1:0]              wb_result_w,
  output logic [NUM_SRC*2-1:0]          fwd_sel_e,
  output logic [NUM_SRC*WIDTH-1:0]      operand_e,
  output logic                          stall_f,
  output logic                          stall_d,
  output logic                          flush_d,
  output logic                          flush_e
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                   fwd_count_m,
  output logic [31:0]                   fwd_count_w,
  output logic [31:0]                   stall_count
`endif
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [2:0] LAT_CNT = 3'(LOAD_LAT);

  logic [NUM_SRC-1:0] sel_m;        // operand takes the Memory-stage result
  logic [NUM_SRC-1:0] sel_w;        // operand takes the Writeback result
  logic [NUM_SRC-1:0] lu_match;     // Decode source matches the load's destination
  logic               lu_hit;
  logic               stall_raw;    // stall condition ignoring reset
  logic               stall_act;

  state_t     state_q;
  logic [2:0] cnt_q;

  // Per-operand comparators and operand muxes; x0 is never forwarded and
  // Memory wins over Writeback because it holds the younger value.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] rs_e_i;
      logic [REG_ADDR_W-1:0] rs_d_i;

      assign rs_e_i = rs_e[gi*REG_ADDR_W +: REG_ADDR_W];
      assign rs_d_i = rs_d[gi*REG_ADDR_W +: REG_ADDR_W];

      assign sel_m[gi] = reg_write_m && (rd_m == rs_e_i) && (rs_e_i != '0);
      assign sel_w[gi] = reg_write_w && (rd_w == rs_e_i) && (rs_e_i != '0) && !sel_m[gi];

      assign fwd_sel_e[gi*2 +: 2] = {sel_m[gi], sel_w[gi]};
      assign lu_match[gi]         = (rs_d_i == rd_e);

      // Operand value mux; the unused 11 encoding falls back to the regfile.
      always_comb begin
        case ({sel_m[gi], sel_w[gi]})
          2'b10:   operand_e[gi*WIDTH +: WIDTH] = alu_result_m;
          2'b01:   operand_e[gi*WIDTH +: WIDTH] = wb_result_w;
          default: operand_e[gi*WIDTH +: WIDTH] = rd_data_e[gi*WIDTH +: WIDTH];
        endcase
      end
    end
  endgenerate

  assign lu_hit = load_e && reg_write_e && (rd_e != '0) && (|lu_match);

  // First stall cycle comes straight from the hit; later ones from STALL.
  // A same-cycle squash kills the dependent instruction, so no stall then.
  assign stall_raw = (state_q == STALL) || ((state_q == IDLE) && lu_hit && !flush_req);
  assign stall_act = stall_raw && !reset;

  assign stall_f = stall_act;
  assign stall_d = stall_act;
  assign flush_d = flush_req;
  assign flush_e = flush_req || stall_act;

  // Load-use FSM: cnt holds the remaining extra stall cycles after the first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lu_hit && !flush_req && (LOAD_LAT > 0)) begin
            cnt_q   <= LAT_CNT;
            state_q <= STALL;
          end
        end
        STALL: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] fwd_count_m_q, fwd_count_m_d;
  logic [31:0] fwd_count_w_q, fwd_count_w_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Next counter values; additions wrap naturally at 2^32.
  always_comb begin
    fwd_count_m_d = fwd_count_m_q + 32'($countones(sel_m));
    fwd_count_w_d = fwd_count_w_q + 32'($countones(sel_w));
    stall_count_d = stall_count_q + {31'd0, stall_raw};
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_count_m_q <= 32'd0;
      fwd_count_w_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fwd_count_m_q <= fwd_count_m_d;
      fwd_count_w_q <= fwd_count_w_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_count_m = fwd_count_m_q;
  assign fwd_count_w = fwd_count_w_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed test-plan cases with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (priority lookup for forwarding, remaining-cycle count
// for the load-use stall, running totals for the statistics).
module tb_fwd_hazard_unit;

  localparam int WIDTH = 32;
  localparam int NS    = 2;
  localparam int RW    = 5;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NS*RW-1:0]     rs_d, rs_e;
  logic [NS*WIDTH-1:0]  rd_data_e;
  logic [RW-1:0]        rd_e, rd_m, rd_w;
  logic                 reg_write_e, reg_write_m, reg_write_w;
  logic                 load_e, flush_req;
  logic [WIDTH-1:0]     alu_result_m, wb_result_w;
  logic [NS*2-1:0]      fwd_sel_e;
  logic [NS*WIDTH-1:0]  operand_e;
  logic                 stall_f, stall_d, flush_d, flush_e;
`ifdef FWD_STATS_EN
  logic [31:0]          fwd_count_m, fwd_count_w, stall_count;
`endif

  logic [RW-1:0]    rs_d_a [NS];
  logic [RW-1:0]    rs_e_a [NS];
  logic [WIDTH-1:0] rd_a   [NS];

  always_comb begin
    rs_d = '0;
    rs_e = '0;
    rd_data_e = '0;
    for (int i = 0; i < NS; i++) begin
      rs_d[i*RW +: RW]         = rs_d_a[i];
      rs_e[i*RW +: RW]         = rs_e_a[i];
      rd_data_e[i*WIDTH +: WIDTH] = rd_a[i];
    end
  end

  fwd_hazard_unit #(
    .WIDTH(WIDTH), .NUM_SRC(NS), .REG_ADDR_W(RW), .LOAD_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rs_e(rs_e), .rd_data_e(rd_data_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .flush_req(flush_req),
    .alu_result_m(alu_result_m), .wb_result_w(wb_result_w),
    .fwd_sel_e(fwd_sel_e), .operand_e(operand_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e)
`ifdef FWD_STATS_EN
    , .fwd_count_m(fwd_count_m), .fwd_count_w(fwd_count_w), .stall_count(stall_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Behavioural model state
  int          rem = 0;          // stall cycles still owed after the current one
  bit [31:0]   m_cnt_m = 0, m_cnt_w = 0, m_cnt_s = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
  endtask

  function automatic logic [1:0] m_sel(int i);
    if (rs_e_a[i] != 0 && reg_write_m && rd_m == rs_e_a[i]) return 2'b10;
    if (rs_e_a[i] != 0 && reg_write_w && rd_w == rs_e_a[i]) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_hit();
    bit any = 0;
    for (int i = 0; i < NS; i++) if (rs_d_a[i] == rd_e) any = 1;
    return load_e && reg_write_e && (rd_e != 0) && any;
  endfunction

  function automatic bit m_stall();
    return !reset && ((rem > 0) || (m_hit() && !flush_req));
  endfunction

  task automatic compare_all();
    bit st;
    st = m_stall();
    for (int i = 0; i < NS; i++) begin
      logic [1:0]       s;
      logic [WIDTH-1:0] v;
      s = m_sel(i);
      v = (s == 2'b10) ? alu_result_m : (s == 2'b01) ? wb_result_w : rd_a[i];
      chk($sformatf("fwd_sel[%0d]", i), 64'(fwd_sel_e[i*2 +: 2]), 64'(s));
      chk($sformatf("operand[%0d]", i), 64'(operand_e[i*WIDTH +: WIDTH]), 64'(v));
    end
    chk("stall_f", 64'(stall_f), 64'(st));
    chk("stall_d", 64'(stall_d), 64'(st));
    chk("flush_d", 64'(flush_d), 64'(flush_req));
    chk("flush_e", 64'(flush_e), 64'(flush_req | st));
`ifdef FWD_STATS_EN
    chk("fwd_count_m", 64'(fwd_count_m), 64'(reset ? 32'd0 : m_cnt_m));
    chk("fwd_count_w", 64'(fwd_count_w), 64'(reset ? 32'd0 : m_cnt_w));
    chk("stall_count", 64'(stall_count), 64'(reset ? 32'd0 : m_cnt_s));
`endif
  endtask

  task automatic update_model();
    bit st;
    st = m_stall();
    if (reset) begin
      rem = 0; m_cnt_m = 0; m_cnt_w = 0; m_cnt_s = 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (m_sel(i) == 2'b10) m_cnt_m++;
        if (m_sel(i) == 2'b01) m_cnt_w++;
      end
      if (st) m_cnt_s++;
      if (rem > 0) rem--;
      else if (m_hit() && !flush_req) rem = LAT;
    end
  endtask

  // Called just after a negedge with inputs set: compare, clock, advance.
  task automatic step();
    #1 compare_all();
    @(posedge clk);
    update_model();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NS; i++) begin
      rs_d_a[i] = RW'(i + 1); rs_e_a[i] = '0; rd_a[i] = 32'h1000 + i;
    end
    rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    load_e = 0; flush_req = 0;
    alu_result_m = 32'hDEAD0001; wb_result_w = 32'hBEEF0002;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(negedge clk);
    #1;
    chk("reset stall_f", 64'(stall_f), 64'(0));
    chk("reset flush_e", 64'(flush_e), 64'(0));
`ifdef FWD_STATS_EN
    chk("reset stall_count", 64'(stall_count), 64'(0));
`endif
    @(negedge clk);
    step();
    reset = 0;
    step();

    // Memory beats Writeback for the same register
    rs_e_a[0] = 5; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1;
    alu_result_m = 32'hAAAA0000; wb_result_w = 32'h11;
    #1;
    chk("tp1 sel0", 64'(fwd_sel_e[1:0]), 64'(2'b10));
    chk("tp1 op0", 64'(operand_e[31:0]), 64'h0000_0000_AAAA_0000);
    step();

    // x0 never forwarded
    idle_inputs();
    rs_e_a[1] = 0; rd_m = 0; reg_write_m = 1; rd_a[1] = 32'h12345678;
    #1;
    chk("tp2 sel1", 64'(fwd_sel_e[3:2]), 64'(2'b00));
    chk("tp2 op1", 64'(operand_e[63:32]), 64'h1234_5678);
    step();

    // Writeback-only forwarding
    idle_inputs();
    rs_e_a[1] = 9; rd_w = 9; reg_write_w = 1; wb_result_w = 32'h0BADF00D;
    #1;
    chk("w sel1", 64'(fwd_sel_e[3:2]), 64'(2'b01));
    chk("w op1", 64'(operand_e[63:32]), 64'h0BAD_F00D);
    step();

    // Load-use: exactly 1+LAT stall cycles
    idle_inputs();
    load_e = 1; reg_write_e = 1; rd_e = 7; rs_d_a[0] = 3; rs_d_a[1] = 7;
    #1;
    chk("lu c1 stall_f", 64'(stall_f), 64'(1));
    step();
    idle_inputs();
    #1; chk("lu c2 stall_d", 64'(stall_d), 64'(1));
    step();
    #1; chk("lu c3 flush_e", 64'(flush_e), 64'(1));
    step();
    #1; chk("lu c4 stall_f", 64'(stall_f), 64'(0));
    chk("lu c4 flush_e", 64'(flush_e), 64'(0));
    step();

    // Hit with squash: no stall, flush for one cycle
    load_e = 1; reg_write_e = 1; rd_e = 7; rs_d_a[1] = 7; flush_req = 1;
    #1;
    chk("sq stall_f", 64'(stall_f), 64'(0));
    chk("sq flush_d", 64'(flush_d), 64'(1));
    chk("sq flush_e", 64'(flush_e), 64'(1));
    step();
    idle_inputs();
    #1;
    chk("sq next stall", 64'(stall_f), 64'(0));
    chk("sq next flush_e", 64'(flush_e), 64'(0));
    step();

    // Reset in the second stall cycle
    load_e = 1; reg_write_e = 1; rd_e = 7; rs_d_a[1] = 7;
    step();
    idle_inputs();
    #1;
    chk("rst pre stall", 64'(stall_f), 64'(1));
    reset = 1;
    #1;
    chk("rst stall_f", 64'(stall_f), 64'(0));
    chk("rst flush_e", 64'(flush_e), 64'(0));
`ifdef FWD_STATS_EN
    chk("rst stall_count", 64'(stall_count), 64'(0));
`endif
    step();
    reset = 0;
    #1;
    chk("rst idle stall", 64'(stall_f), 64'(0));
    step();

    // Four cycles of both operands forwarding from W, counted from reset
    reset = 1;
    step();
    reset = 0;
    rs_e_a[0] = 4; rs_e_a[1] = 4; rd_w = 4; reg_write_w = 1;
    repeat (4) step();
    idle_inputs();
    #1;
`ifdef FWD_STATS_EN
    chk("stats w", 64'(fwd_count_w), 64'(8));
    chk("stats m", 64'(fwd_count_m), 64'(0));
`endif
    step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NS; i++) begin
        rs_d_a[i] = RW'($urandom_range(0, 3));
        rs_e_a[i] = RW'($urandom_range(0, 3));
        rd_a[i]   = $urandom;
      end
      rd_e = RW'($urandom_range(0, 3));
      rd_m = RW'($urandom_range(0, 3));
      rd_w = RW'($urandom_range(0, 3));
      reg_write_e = ($urandom_range(0, 3) != 0);
      reg_write_m = ($urandom_range(0, 1) != 0);
      reg_write_w = ($urandom_range(0, 1) != 0);
      load_e      = ($urandom_range(0, 2) == 0);
      flush_req   = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 49) == 0);
      alu_result_m = $urandom;
      wb_result_w  = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined RISC-V core, replacing the fixed two-operand, per-operand forwarding muxes. It compares Execute-stage source registers against the Memory and Writeback destinations for `NUM_SRC` operands and drives the forwarded operand values. It also runs a load-use stall state machine that holds Fetch/Decode and bubbles Execute for `1+LOAD_LAT` cycles. It sits between the Decode/Execute pipeline registers and the ALU operand inputs.

## Interface
- `WIDTH`, 32, data width of operands and results
- `NUM_SRC`, 2, number of source operands forwarded (1..4)
- `REG_ADDR_W`, 5, register index width
- `LOAD_LAT`, 0, extra data-memory latency cycles covered by load-use stall (0..7)

- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rs_d`  in  NUM_SRC*REG_ADDR_W  source register indices in Decode, operand i at slice i
- `rs_e`  in  NUM_SRC*REG_ADDR_W  source register indices in Execute
- `rd_data_e`  in  NUM_SRC*WIDTH  register-file read data in Execute
- `rd_e`, `rd_m`, `rd_w`  in  REG_ADDR_W each  destination indices in E/M/W
- `reg_write_e`, `reg_write_m`, `reg_write_w`  in  1 each  destination write enables
- `load_e`  in  1  instruction in Execute is a load
- `flush_req`  in  1  taken branch/jump resolved in Execute
- `alu_result_m`  in  WIDTH  ALU result in Memory
- `wb_result_w`  in  WIDTH  writeback result
- `fwd_sel_e`  out  NUM_SRC*2  per-operand select: 00 regfile, 01 W, 10 M
- `operand_e`  out  NUM_SRC*WIDTH  forwarded operand values
- `stall_f`, `stall_d`  out  1  hold PC and F/D register
- `flush_d`, `flush_e`  out  1  clear F/D and D/E registers
- `fwd_count_m`, `fwd_count_w`, `stall_count`  out  32 each  statistics (only with `FWD_STATS_EN`)

## Operation
- Forwarding, per operand i, combinational: select 10 if `reg_write_m` and `rd_m==rs_e[i]` and `rs_e[i]!=0`; else 01 if the same holds for W; else 00. M has priority over W. x0 is never forwarded.
- `operand_e[i]` = `rd_data_e[i]` / `wb_result_w` / `alu_result_m` for 00/01/10; 11 is never produced and maps to `rd_data_e[i]`.
- Load-use hit: `load_e & reg_write_e & rd_e!=0` and `rd_e` equals any `rs_d[i]`.
- FSM states IDLE, STALL; 3-bit counter `cnt`.
  - IDLE, hit, no `flush_req`: assert `stall_f`, `stall_d`, `flush_e` this cycle. If `LOAD_LAT>0`, load `cnt=LOAD_LAT` and go to STALL; otherwise remain in IDLE.
  - STALL: assert `stall_f`, `stall_d`, `flush_e`. Decrement `cnt`. When `cnt==1`, return to IDLE.
  - Hit and `flush_req` in the same cycle: no stall; the squash wins.
- `flush_req` drives `flush_d=1` and `flush_e=1` combinationally in any state.
- Values past W are obtained through the write-through register file; they are not forwarded.

## Timing
- Forwarding path: zero latency, purely combinational from inputs to `fwd_sel_e`/`operand_e`.
- Stall length: exactly `1+LOAD_LAT` consecutive cycles per hit. Outputs in the first cycle are combinational from the hit; later cycles come from state.
- Reset (asynchronous, any time including mid-STALL): state=IDLE, `cnt=0`, counters=0. Stall and flush outputs return to 0 immediately unless `flush_req` is high. Forwarding outputs stay combinational.
- A new hit detected on the cycle STALL exits to IDLE is evaluated normally in the following IDLE cycle.

## Configuration
- `FWD_STATS_EN` defined:
  - `fwd_count_m` increments by the number of operands selecting M each cycle.
  - `fwd_count_w` increments by the number of operands selecting W each cycle.
  - `stall_count` increments on every cycle `stall_d` is high.
  - All counters are 32-bit, wrap at 2^32-1 → 0, and reset to 0.
- `FWD_STATS_EN` undefined: the counter ports and logic are absent. The remaining behaviour is identical.

## Test plan
- `rs_e[0]=5`, `rd_m=5`, `rd_w=5`, both writes on, `alu_result_m=0xAAAA0000`, `wb_result_w=0x11` -> `fwd_sel_e[0]=10`, `operand_e[0]=0xAAAA0000`.
- `rs_e[1]=0`, `rd_m=0`, `reg_write_m=1` -> `fwd_sel_e[1]=00`, `operand_e[1]=rd_data_e[1]`.
- `LOAD_LAT=2`, `load_e=1`, `rd_e=7`, `rs_d[1]=7` -> `stall_f`/`stall_d`/`flush_e` high for exactly 3 cycles, then low.
- Same hit with `flush_req=1` -> no stall; `flush_d=flush_e=1` for one cycle.
- `reset` pulsed in the 2nd stall cycle -> stall outputs drop before the next edge; FSM in IDLE; `stall_count=0` with `FWD_STATS_EN`.
- With `FWD_STATS_EN`, 4 cycles with both operands forwarding from W -> `fwd_count_w=8`, `fwd_count_m=0`.
